// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding and
// default sizing.
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa_from_ha.sv
// Combinational full adder composed of two half adders with an OR merging the
// two partial carries.
module fa_from_ha (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    // At most one of the partial carries can be set, so OR is sufficient.
    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single half-adder cell; the basic building block of the lab's adders.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, a registered carry and
// three shift registers, sequenced by a small IDLE/SHIFT/DONE FSM.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] r_sr_q,   r_sr_d;
    logic             c_q,      c_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic fa_s;
    logic fa_co;

    fa_from_ha u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE so start held high
            // gives back-to-back operations.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = {fa_s, r_sr_q[WIDTH-1:1]};
                c_d    = fa_co;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = r_sr_d;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed scenarios plus random
// operations on an 8-bit instance, and an exhaustive sweep of a 4-bit instance.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int numCompared = 0;
    int numMismatched = 0;

    // Reference model state: the last result the 8-bit adder should be holding.
    logic [7:0] expSum = '0;
    logic       expCout = 1'b0;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic expBusy, input logic expDone);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "_sum"},  32'(sum),  32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
    endtask

    // One full operation on the 8-bit adder; optionally scrambles the inputs
    // and pulses start while the operation is in flight.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tcin, input bit scramble);
        logic [8:0] total;
        total = 9'(ta) + 9'(tb) + 9'(tcin);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tcin;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkState("shift", 1'b1, 1'b0);
            if (scramble && k < 7) begin
                a = 8'($urandom); b = 8'($urandom);
                cin = 1'($urandom); start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        expSum  = total[7:0];
        expCout = total[8];
        @(negedge clk);
        checkState("done", 1'b0, 1'b1);
        @(negedge clk);
        checkState("after", 1'b0, 1'b0);
    endtask

    // Two operations with start held high; the second is accepted in DONE.
    task automatic backToBack(input logic [7:0] a1, input logic [7:0] b1,
                              input logic [7:0] a2, input logic [7:0] b2);
        logic [8:0] r1;
        logic [8:0] r2;
        r1 = 9'(a1) + 9'(b1);
        r2 = 9'(a2) + 9'(b2);
        @(negedge clk);
        start = 1'b1; a = a1; b = b1; cin = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a = a2; b = b2;
            end
            if (k == 8) begin
                expSum = r1[7:0]; expCout = r1[8];
            end
            if (k == 17) begin
                expSum = r2[7:0]; expCout = r2[8];
            end
            checkState("b2b", ((k % 9) != 8), ((k % 9) == 8));
            if (k == 17) start = 1'b0;
        end
        @(negedge clk);
        checkState("b2b_end", 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        logic [4:0] exp4;

        // Reset held low with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            checkState("reset", 1'b0, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkState("idle", 1'b0, 1'b0);
        end

        $display("[TB] overflow wrap");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        checkOutput("ff_plus_1", {23'b0, cout, sum}, 32'h100);

        $display("[TB] inputs changed mid-operation");
        applyStimulus(8'h5A, 8'h25, 1'b1, 1'b1);
        checkOutput("5a_plus_25", {23'b0, cout, sum}, 32'h080);

        $display("[TB] start held high");
        backToBack(8'h01, 8'h02, 8'h10, 8'h20);
        checkOutput("b2b_final", {23'b0, cout, sum}, 32'h030);

        $display("[TB] reset mid-operation");
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h7E; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expSum = '0; expCout = 1'b0;
        checkState("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        checkState("rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkState("rst_rel", 1'b0, 1'b0);
        applyStimulus(8'h3C, 8'h4B, 1'b0, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        $display("[TB] 4-bit exhaustive");
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci);
                    @(posedge clk);
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
                    lat = 0;
                    while (!done4 && lat < 12) begin
                        @(negedge clk);
                        lat++;
                    end
                    exp4 = 5'(ai + bi + ci);
                    checkOutput("lat4", 32'(lat), 32'd4);
                    checkOutput("res4", 32'({cout4, sum4}), 32'(exp4));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
